top_clk_v6: RTL and testbench
=============================

TOP_CLK_V6 -- requirements
Module: top_clk_v6

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per second tick (legal range 2 and up).
REQ-002 Parameter RING_SECS, default 30, seconds alarm_ring stays high without acknowledge (legal range 1 to 63).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 hour_12  input  1  display mode: 1 = 12-hour, 0 = 24-hour; affects display only.
REQ-006 load  input  1  write strobe, sampled each cycle.
REQ-007 addrs  input  3  write target: 0 sec, 1 min, 2 hr, 3 alarm min, 4 alarm hr, 5 alarm enable, 6-7 reserved.
REQ-008 data_in  input  6  write value, binary.
REQ-009 alarm_ack  input  1  clears alarm_ring.
REQ-010 sec_pulse  output  1  one-cycle pulse per second tick.
REQ-011 load_err  output  1  one-cycle pulse on a rejected write.
REQ-012 pm  output  1  1 when hours are 12-23 and hour_12=1, else 0.
REQ-013 alarm_ring  output  1  alarm active.
REQ-014 left/right_seconds_out, left/right_minutes_out, left/right_hours_out  output  4 each  BCD digits (tens/units).

Function
REQ-015 Prescaler counts 0..TICK_DIV-1 and wraps; sec_pulse is high exactly in the cycle the count equals TICK_DIV-1.
REQ-016 On a tick: seconds 0..59 increment; 59 wraps to 0 and carries to minutes; minutes 59 wraps and carries to hours; hours 23 wraps to 0 (23:59:59 -> 00:00:00 in one tick).
REQ-017 Hours are stored 0..23 internally; 12-hour display maps 0 -> 12 and 13..23 -> 1..11.
REQ-018 A write takes effect on the edge where load=1.
  - Legal ranges: sec/min/alarm min 0..59; hr/alarm hr 0..23; enable uses data_in[0].
  - An out-of-range value or reserved address leaves all registers unchanged and pulses load_err on the following cycle.
REQ-019 A write to addrs 0 also clears the prescaler, so the next tick arrives TICK_DIV cycles later.
REQ-020 Load coincident with a tick: the addressed field takes data_in; unaddressed fields advance as in REQ-016; a carry out of the written field is suppressed.
REQ-021 alarm_ring rises on the tick that makes time equal alarm hr:min:00 while the alarm is enabled.
REQ-022 alarm_ring falls on whichever comes first: alarm_ack=1, or RING_SECS further ticks.
  - Clearing the alarm enable also drops alarm_ring on the next edge.
  - alarm_ack coincident with a new match leaves alarm_ring high.
REQ-023 BCD outputs and pm are combinational from the time registers and reflect a new value in the cycle after the updating edge.

Reset
REQ-024 While reset=0, all of the following hold:
  - Prescaler, seconds, minutes, hours and alarm min/hr are 0.
  - Alarm is disabled.
  - sec_pulse, load_err, alarm_ring and pm are 0.
  - All BCD digits are 0, except right_hours_out = 2 and left_hours_out = 1 when hour_12=1.
REQ-025 Reset asserted mid-operation overrides any pending load, tick or ring immediately (asynchronously).

Configuration
REQ-026 Macro CLK_ALARM_EN: when defined, REQ-021/022 apply in full.
REQ-027 Without CLK_ALARM_EN:
  - Alarm registers are absent.
  - alarm_ring is tied 0 and alarm_ack is ignored.
  - addrs 3-5 are treated as reserved (load_err pulse).

Structure
REQ-028 The shared package clk_pkg holds the address constants, the field limits 59 and 23, and the RING_SECS limit 63.
REQ-029 The prescaler is a separate sub-module clk_prescaler (inputs clk, reset, clr; output tick).
REQ-030 BCD conversion reuses the existing binary-to-BCD converters.

Verification (TICK_DIV=4, RING_SECS=3)
REQ-031 Write hr 23, min 59, sec 59, then one tick -> all digits 0 and pm=0.
REQ-032 hour_12=1 with hr 0 then hr 13 -> "12" with pm=0, then "01" with pm=1.
REQ-033 Write sec 60, then write addrs 7 -> load_err pulses twice and seconds are unchanged.
REQ-034 Write sec 59 on the same edge as a tick with min=5 -> sec=59, min=5 (no carry).
REQ-035 Alarm 00:01 enabled, time 00:00:59, one tick -> alarm_ring=1; after 3 ticks -> 0. Repeat with alarm_ack one cycle after rise -> 0 on the next edge.
REQ-036 reset=0 asynchronously mid-count with alarm_ring=1 -> all outputs reach reset values without a clk edge.

Source files
------------

// File: rtl/clk_pkg.sv
// Shared constants for the real-time clock: write addresses, field limits,
// the ring-duration ceiling and the binary-to-BCD digit converter.
package clk_pkg;

    // Write targets selected by addrs; 6 and 7 are reserved.
    typedef enum logic [2:0] {
        ADDR_SEC     = 3'd0,
        ADDR_MIN     = 3'd1,
        ADDR_HR      = 3'd2,
        ADDR_ALM_MIN = 3'd3,
        ADDR_ALM_HR  = 3'd4,
        ADDR_ALM_EN  = 3'd5
    } addr_e;

    localparam logic [5:0] SEC_MAX       = 6'd59;
    localparam logic [5:0] MIN_MAX       = 6'd59;
    localparam logic [4:0] HR_MAX        = 5'd23;
    localparam int         RING_SECS_MAX = 63;

    // Binary 0..63 to two BCD digits {tens, units}. The units digit is
    // computed modulo 16, which is exact because the true result is below 10.
    function automatic logic [7:0] bin_to_bcd(input logic [5:0] value);
        logic [3:0] tens;
        logic [3:0] units;
        if (value >= 6'd60)      tens = 4'd6;
        else if (value >= 6'd50) tens = 4'd5;
        else if (value >= 6'd40) tens = 4'd4;
        else if (value >= 6'd30) tens = 4'd3;
        else if (value >= 6'd20) tens = 4'd2;
        else if (value >= 6'd10) tens = 4'd1;
        else                     tens = 4'd0;
        units = value[3:0] - tens * 4'd10;
        return {tens, units};
    endfunction

endpackage

// File: rtl/top_clk_v6_if.sv
// Register-write bus of the clock: strobe, address, data and the
// rejected-write pulse returned by the clock.
interface top_clk_v6_if;
    logic       load;
    logic [2:0] addrs;
    logic [5:0] data_in;
    logic       load_err;

    modport master (output load, output addrs, output data_in, input load_err);
    modport slave  (input load, input addrs, input data_in, output load_err);
endinterface

// File: rtl/clk_prescaler.sv
// Seconds prescaler: counts 0..TICK_DIV-1 and flags the last count as the tick.
// clr restarts the count so the next tick is a full period away.
module clk_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    // Free-running divider with wrap and synchronous restart.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (clr || count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = (count_reg == LAST);
endmodule

// File: rtl/top_clk_v6.sv
// Real-time clock with register write bus, 12/24-hour BCD display and an
// optional alarm. Define CLK_ALARM_EN to build the alarm registers and ring
// logic; without it alarm addresses are rejected and alarm_ring stays 0.
module top_clk_v6 #(
    parameter int TICK_DIV  = 50000000,
    parameter int RING_SECS = 30
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            hour_12,
    input  logic            alarm_ack,
    top_clk_v6_if.slave     wr,
    output logic            sec_pulse,
    output logic            pm,
    output logic            alarm_ring,
    output logic [3:0]      left_seconds_out,
    output logic [3:0]      right_seconds_out,
    output logic [3:0]      left_minutes_out,
    output logic [3:0]      right_minutes_out,
    output logic [3:0]      left_hours_out,
    output logic [3:0]      right_hours_out
);
    import clk_pkg::*;

    // Ring lasts RING_SECS ticks after the rising tick; counter ends at N-1.
    localparam logic [5:0] RING_LAST =
        6'(((RING_SECS > RING_SECS_MAX) ? RING_SECS_MAX : RING_SECS) - 1);

    logic       tick;
    addr_e      wr_addr;
    logic       wr_legal;
    logic       wr_ok;
    logic       wr_sec, wr_min, wr_hr;
    logic       sec_carry, min_carry;
    logic [5:0] sec_reg, min_reg;
    logic [4:0] hr_reg;
    logic [5:0] sec_next, min_next;
    logic [4:0] hr_next;
    logic       load_err_reg;
    logic [4:0] hr_disp;

    clk_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (wr_sec),
        .tick  (tick)
    );

    assign wr_addr = addr_e'(wr.addrs);

    // Address/value legality of the current write.
    always_comb begin
        wr_legal = 1'b0;
        case (wr_addr)
            ADDR_SEC:     wr_legal = (wr.data_in <= SEC_MAX);
            ADDR_MIN:     wr_legal = (wr.data_in <= MIN_MAX);
            ADDR_HR:      wr_legal = (wr.data_in <= {1'b0, HR_MAX});
`ifdef CLK_ALARM_EN
            ADDR_ALM_MIN: wr_legal = (wr.data_in <= MIN_MAX);
            ADDR_ALM_HR:  wr_legal = (wr.data_in <= {1'b0, HR_MAX});
            ADDR_ALM_EN:  wr_legal = 1'b1;
`endif
            default:      wr_legal = 1'b0;
        endcase
    end

    assign wr_ok  = wr.load && wr_legal;
    assign wr_sec = wr_ok && (wr_addr == ADDR_SEC);
    assign wr_min = wr_ok && (wr_addr == ADDR_MIN);
    assign wr_hr  = wr_ok && (wr_addr == ADDR_HR);

    // Next time: a written field takes the data and never carries onward,
    // the other fields advance on the tick as usual.
    always_comb begin
        sec_carry = tick && (sec_reg == SEC_MAX) && !wr_sec;
        min_carry = sec_carry && (min_reg == MIN_MAX) && !wr_min;
        sec_next  = sec_reg;
        min_next  = min_reg;
        hr_next   = hr_reg;
        if (wr_sec)
            sec_next = wr.data_in;
        else if (tick)
            sec_next = (sec_reg == SEC_MAX) ? 6'd0 : sec_reg + 6'd1;
        if (wr_min)
            min_next = wr.data_in;
        else if (sec_carry)
            min_next = (min_reg == MIN_MAX) ? 6'd0 : min_reg + 6'd1;
        if (wr_hr)
            hr_next = wr.data_in[4:0];
        else if (min_carry)
            hr_next = (hr_reg == HR_MAX) ? 5'd0 : hr_reg + 5'd1;
    end

    // Time registers and the rejected-write pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_reg      <= '0;
            min_reg      <= '0;
            hr_reg       <= '0;
            load_err_reg <= 1'b0;
        end else begin
            sec_reg      <= sec_next;
            min_reg      <= min_next;
            hr_reg       <= hr_next;
            load_err_reg <= wr.load && !wr_legal;
        end
    end

`ifdef CLK_ALARM_EN
    logic [5:0] alm_min_reg;
    logic [4:0] alm_hr_reg;
    logic       alm_en_reg;
    logic       alm_en_next;
    logic       alm_match;
    logic       ring_reg;
    logic [5:0] ring_cnt_reg;

    // A match needs a tick landing exactly on alarm hr:min:00.
    always_comb begin
        alm_en_next = (wr_ok && wr_addr == ADDR_ALM_EN) ? wr.data_in[0] : alm_en_reg;
        alm_match   = tick && alm_en_next && (sec_next == 6'd0) &&
                      (min_next == alm_min_reg) && (hr_next == alm_hr_reg);
    end

    // Alarm setting registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alm_min_reg <= '0;
            alm_hr_reg  <= '0;
            alm_en_reg  <= 1'b0;
        end else begin
            if (wr_ok && wr_addr == ADDR_ALM_MIN) alm_min_reg <= wr.data_in;
            if (wr_ok && wr_addr == ADDR_ALM_HR)  alm_hr_reg  <= wr.data_in[4:0];
            alm_en_reg <= alm_en_next;
        end
    end

    // Ring: a new match wins over ack; ack or disable drop it; otherwise
    // it expires on the RING_SECS-th tick after rising.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ring_reg     <= 1'b0;
            ring_cnt_reg <= '0;
        end else if (alm_match) begin
            ring_reg     <= 1'b1;
            ring_cnt_reg <= '0;
        end else if (alarm_ack || !alm_en_next) begin
            ring_reg     <= 1'b0;
        end else if (ring_reg && tick) begin
            if (ring_cnt_reg == RING_LAST)
                ring_reg <= 1'b0;
            else
                ring_cnt_reg <= ring_cnt_reg + 6'd1;
        end
    end

    assign alarm_ring = ring_reg;
`else
    logic       unused_alarm_ack;
    logic [5:0] unused_ring_last;
    assign unused_alarm_ack = alarm_ack;
    assign unused_ring_last = RING_LAST;
    assign alarm_ring       = 1'b0;
`endif

    // 12-hour display maps 0 to 12 and 13..23 to 1..11.
    always_comb begin
        hr_disp = hr_reg;
        if (hour_12) begin
            if (hr_reg == 5'd0)
                hr_disp = 5'd12;
            else if (hr_reg > 5'd12)
                hr_disp = hr_reg - 5'd12;
        end
    end

    assign sec_pulse   = tick;
    assign wr.load_err = load_err_reg;
    assign pm          = hour_12 && (hr_reg >= 5'd12);

    assign {left_seconds_out, right_seconds_out} = bin_to_bcd(sec_reg);
    assign {left_minutes_out, right_minutes_out} = bin_to_bcd(min_reg);
    assign {left_hours_out,   right_hours_out}   = bin_to_bcd({1'b0, hr_disp});
endmodule

// File: tb/tb_top_clk_v6.sv
// Self-checking bench for top_clk_v6 with TICK_DIV=4, RING_SECS=3.
// The reference model keeps time as seconds-of-day and re-derives fields
// with division/modulo.
module tb_top_clk_v6;
    localparam int TD = 4;
    localparam int RS = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic hour_12 = 1'b0;
    logic alarm_ack = 1'b0;
    logic sec_pulse, pm, alarm_ring;
    logic [3:0] left_seconds_out, right_seconds_out;
    logic [3:0] left_minutes_out, right_minutes_out;
    logic [3:0] left_hours_out, right_hours_out;
    logic [23:0] obs_digits;

    top_clk_v6_if wr_bus ();

    top_clk_v6 #(.TICK_DIV(TD), .RING_SECS(RS)) dut (
        .clk               (clk),
        .reset             (reset),
        .hour_12           (hour_12),
        .alarm_ack         (alarm_ack),
        .wr                (wr_bus),
        .sec_pulse         (sec_pulse),
        .pm                (pm),
        .alarm_ring        (alarm_ring),
        .left_seconds_out  (left_seconds_out),
        .right_seconds_out (right_seconds_out),
        .left_minutes_out  (left_minutes_out),
        .right_minutes_out (right_minutes_out),
        .left_hours_out    (left_hours_out),
        .right_hours_out   (right_hours_out)
    );

    assign obs_digits = {left_hours_out, right_hours_out, left_minutes_out,
                         right_minutes_out, left_seconds_out, right_seconds_out};

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int m_t, m_phase, m_amin, m_ahr, m_rcnt;
    bit m_err, m_en, m_ring;

    function automatic void model_reset();
        m_t = 0; m_phase = 0; m_amin = 0; m_ahr = 0; m_rcnt = 0;
        m_err = 0; m_en = 0; m_ring = 0;
    endfunction

    function automatic logic [23:0] exp_digits(input int t, input bit h12);
        int hh, mm, ss;
        hh = t / 3600; mm = (t / 60) % 60; ss = t % 60;
        if (h12) begin
            if (hh == 0) hh = 12;
            else if (hh > 12) hh = hh - 12;
        end
        return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic bit exp_pm(input int t, input bit h12);
        return h12 && (t / 3600 >= 12);
    endfunction

    // Advance the model across one rising edge using the current inputs.
    function automatic void model_edge();
        bit tick, legal, en_new;
        int a, d, t2, hh, mm, ss;
        tick = (m_phase == TD - 1);
        a = int'(wr_bus.addrs);
        d = int'(wr_bus.data_in);
        legal = 0;
        case (a)
            0, 1: legal = (d < 60);
            2:    legal = (d < 24);
`ifdef CLK_ALARM_EN
            3:    legal = (d < 60);
            4:    legal = (d < 24);
            5:    legal = 1;
`endif
            default: legal = 0;
        endcase
        legal = legal && wr_bus.load;
        t2 = tick ? (m_t + 1) % 86400 : m_t;
        if (legal && a <= 2) begin
            hh = t2 / 3600; mm = (t2 / 60) % 60; ss = t2 % 60;
            if (a == 0) begin hh = m_t / 3600; mm = (m_t / 60) % 60; ss = d; end
            else if (a == 1) begin hh = m_t / 3600; mm = d; end
            else hh = d;
            t2 = hh * 3600 + mm * 60 + ss;
        end
        en_new = (legal && a == 5) ? d[0] : m_en;
        if (tick && en_new && t2 == m_ahr * 3600 + m_amin * 60) begin
            m_ring = 1; m_rcnt = 0;
        end else if (alarm_ack || !en_new) begin
            m_ring = 0;
        end else if (m_ring && tick) begin
            m_rcnt++;
            if (m_rcnt == RS) m_ring = 0;
        end
        if (legal && a == 3) m_amin = d;
        if (legal && a == 4) m_ahr = d;
        m_en = en_new;
        m_phase = (legal && a == 0) ? 0 : (m_phase + 1) % TD;
        m_err = wr_bus.load && !legal;
        m_t = t2;
    endfunction

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [5:0] d);
        wr_bus.load = 1'b1; wr_bus.addrs = a; wr_bus.data_in = d;
        step();
        wr_bus.load = 1'b0;
        $display("write addr=%0d data=%0d load_err=%b time=%h", a, d, wr_bus.load_err, obs_digits);
    endtask

    task automatic align_tick();
        for (int i = 0; i < TD && m_phase != TD - 1; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b0; hour_12 = 1'b0; alarm_ack = 1'b0;
        wr_bus.load = 1'b0; wr_bus.addrs = 3'd0; wr_bus.data_in = 6'd0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({sec_pulse, wr_bus.load_err, alarm_ring, pm} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {sec_pulse, wr_bus.load_err, alarm_ring, pm});
        end
        checks++;
        if (obs_digits !== 24'h000000) begin
            errors++; $display("FAIL reset_digits_24h: got %h want 000000", obs_digits);
        end
        hour_12 = 1'b1; #1;
        checks++;
        if (obs_digits !== 24'h120000) begin
            errors++; $display("FAIL reset_digits_12h: got %h want 120000", obs_digits);
        end
        hour_12 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_rollover();
        do_write(3'd2, 6'd23); do_write(3'd1, 6'd59); do_write(3'd0, 6'd59);
        repeat (TD - 2) step();
        checks++;
        if (sec_pulse !== 1'b0) begin
            errors++; $display("FAIL prescaler_early: got sec_pulse=%b want 0", sec_pulse);
        end
        step();
        checks++;
        if (sec_pulse !== 1'b1 || obs_digits !== 24'h235959) begin
            errors++; $display("FAIL pre_rollover: got pulse=%b %h want 1 235959", sec_pulse, obs_digits);
        end
        step();
        checks++;
        if (obs_digits !== 24'h000000 || pm !== 1'b0 || sec_pulse !== 1'b0) begin
            errors++; $display("FAIL rollover: got %h pm=%b pulse=%b want 000000 0 0", obs_digits, pm, sec_pulse);
        end
    endtask

    task automatic test_12h();
        hour_12 = 1'b1;
        do_write(3'd2, 6'd0);
        checks++;
        if ({left_hours_out, right_hours_out} !== 8'h12 || pm !== 1'b0) begin
            errors++; $display("FAIL h12_midnight: got %h pm=%b want 12 0", {left_hours_out, right_hours_out}, pm);
        end
        do_write(3'd2, 6'd13);
        checks++;
        if ({left_hours_out, right_hours_out} !== 8'h01 || pm !== 1'b1) begin
            errors++; $display("FAIL h12_13: got %h pm=%b want 01 1", {left_hours_out, right_hours_out}, pm);
        end
        hour_12 = 1'b0; #1;
        checks++;
        if ({left_hours_out, right_hours_out} !== 8'h13 || pm !== 1'b0) begin
            errors++; $display("FAIL h24_13: got %h pm=%b want 13 0", {left_hours_out, right_hours_out}, pm);
        end
        hour_12 = 1'b1;
        do_write(3'd2, 6'd12);
        checks++;
        if ({left_hours_out, right_hours_out} !== 8'h12 || pm !== 1'b1) begin
            errors++; $display("FAIL h12_noon: got %h pm=%b want 12 1", {left_hours_out, right_hours_out}, pm);
        end
        hour_12 = 1'b0;
    endtask

    task automatic test_load_err();
        do_write(3'd0, 6'd30);
        checks++;
        if (wr_bus.load_err !== 1'b0 || {left_seconds_out, right_seconds_out} !== 8'h30) begin
            errors++; $display("FAIL legal_write: got err=%b sec=%h want 0 30", wr_bus.load_err, {left_seconds_out, right_seconds_out});
        end
        do_write(3'd0, 6'd60);
        checks++;
        if (wr_bus.load_err !== 1'b1 || obs_digits !== exp_digits(m_t, hour_12)) begin
            errors++; $display("FAIL sec60_err: got err=%b %h want 1 %h", wr_bus.load_err, obs_digits, exp_digits(m_t, hour_12));
        end
        do_write(3'd7, 6'd5);
        checks++;
        if (wr_bus.load_err !== 1'b1 || obs_digits !== exp_digits(m_t, hour_12)) begin
            errors++; $display("FAIL addr7_err: got err=%b %h want 1 %h", wr_bus.load_err, obs_digits, exp_digits(m_t, hour_12));
        end
        do_write(3'd2, 6'd24);
        checks++;
        if (wr_bus.load_err !== 1'b1) begin
            errors++; $display("FAIL hr24_err: got err=%b want 1", wr_bus.load_err);
        end
        step();
        checks++;
        if (wr_bus.load_err !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got err=%b want 0", wr_bus.load_err);
        end
`ifndef CLK_ALARM_EN
        do_write(3'd3, 6'd5);
        checks++;
        if (wr_bus.load_err !== 1'b1) begin
            errors++; $display("FAIL alarm_addr_reserved: got err=%b want 1", wr_bus.load_err);
        end
`endif
    endtask

    task automatic test_coincident();
        do_write(3'd2, 6'd4); do_write(3'd1, 6'd5); do_write(3'd0, 6'd10);
        align_tick();
        checks++;
        if (sec_pulse !== 1'b1) begin
            errors++; $display("FAIL align_pulse: got %b want 1", sec_pulse);
        end
        do_write(3'd0, 6'd59);
        checks++;
        if (obs_digits !== 24'h040559) begin
            errors++; $display("FAIL sec_on_tick: got %h want 040559", obs_digits);
        end
        align_tick();
        do_write(3'd1, 6'd59);
        checks++;
        if (obs_digits !== 24'h045900) begin
            errors++; $display("FAIL min_on_tick: got %h want 045900", obs_digits);
        end
        do_write(3'd0, 6'd59);
        align_tick();
        do_write(3'd2, 6'd7);
        checks++;
        if (obs_digits !== 24'h070000) begin
            errors++; $display("FAIL hr_on_tick: got %h want 070000", obs_digits);
        end
    endtask

`ifdef CLK_ALARM_EN
    task automatic arm_time();
        do_write(3'd1, 6'd0); do_write(3'd0, 6'd59);
        repeat (TD - 1) step();
    endtask

    task automatic test_alarm();
        do_write(3'd0, 6'd0); do_write(3'd3, 6'd1); do_write(3'd4, 6'd0);
        do_write(3'd2, 6'd0); do_write(3'd5, 6'd1);
        arm_time();
        checks++;
        if (alarm_ring !== 1'b0) begin
            errors++; $display("FAIL ring_early: got %b want 0", alarm_ring);
        end
        step();
        checks++;
        if (alarm_ring !== 1'b1 || obs_digits !== 24'h000100) begin
            errors++; $display("FAIL ring_rise: got %b %h want 1 000100", alarm_ring, obs_digits);
        end
        repeat (2 * TD + TD - 1) step();
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++; $display("FAIL ring_hold: got %b want 1", alarm_ring);
        end
        step();
        checks++;
        if (alarm_ring !== 1'b0) begin
            errors++; $display("FAIL ring_expire: got %b want 0", alarm_ring);
        end
        arm_time(); step();
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        checks++;
        if (alarm_ring !== 1'b0) begin
            errors++; $display("FAIL ring_ack: got %b want 0", alarm_ring);
        end
        arm_time();
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++; $display("FAIL ack_vs_match: got %b want 1", alarm_ring);
        end
        do_write(3'd5, 6'd0);
        checks++;
        if (alarm_ring !== 1'b0) begin
            errors++; $display("FAIL ring_disable: got %b want 0", alarm_ring);
        end
        do_write(3'd5, 6'd1);
        arm_time(); step();
        checks++;
        if (alarm_ring !== 1'b1) begin
            errors++; $display("FAIL ring_rearm: got %b want 1", alarm_ring);
        end
    endtask
`endif

    task automatic test_async_reset();
        hour_12 = 1'b1;
        do_write(3'd2, 6'd15);
        checks++;
        if (pm !== 1'b1 || alarm_ring !== m_ring) begin
            errors++; $display("FAIL pre_reset: got pm=%b ring=%b want 1 %b", pm, alarm_ring, m_ring);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({sec_pulse, wr_bus.load_err, alarm_ring, pm} !== 4'b0000 || obs_digits !== 24'h120000) begin
            errors++; $display("FAIL async_reset: got %b %h want 0000 120000", {sec_pulse, wr_bus.load_err, alarm_ring, pm}, obs_digits);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1; hour_12 = 1'b0;
        repeat (TD - 1) step();
        checks++;
        if (sec_pulse !== 1'b1) begin
            errors++; $display("FAIL prescaler_after_reset: got %b want 1", sec_pulse);
        end
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 400; i++) begin
            hour_12 = 1'($urandom_range(0, 1));
            alarm_ack = ($urandom_range(0, 15) == 0);
            wr_bus.load = ($urandom_range(0, 3) == 0);
            a = $urandom_range(0, 7);
            wr_bus.addrs = 3'(a);
            if ($urandom_range(0, 7) == 0)   wr_bus.data_in = 6'($urandom_range(0, 63));
            else if (a == 2 || a == 4)       wr_bus.data_in = 6'($urandom_range(0, 23));
            else if (a == 5)                 wr_bus.data_in = 6'($urandom_range(0, 1));
            else                             wr_bus.data_in = 6'($urandom_range(0, 59));
            step();
            if (wr_bus.load)
                $display("rand write addr=%0d data=%0d time=%h", wr_bus.addrs, wr_bus.data_in, obs_digits);
            checks++;
            if (sec_pulse !== (m_phase == TD - 1)) begin
                errors++; $display("FAIL rand_pulse[%0d]: got %b want %b", i, sec_pulse, m_phase == TD - 1);
            end
            checks++;
            if (wr_bus.load_err !== m_err) begin
                errors++; $display("FAIL rand_load_err[%0d]: got %b want %b", i, wr_bus.load_err, m_err);
            end
            checks++;
            if (alarm_ring !== m_ring) begin
                errors++; $display("FAIL rand_ring[%0d]: got %b want %b", i, alarm_ring, m_ring);
            end
            checks++;
            if (obs_digits !== exp_digits(m_t, hour_12) || pm !== exp_pm(m_t, hour_12)) begin
                errors++; $display("FAIL rand_display[%0d]: got %h pm=%b want %h pm=%b", i, obs_digits, pm, exp_digits(m_t, hour_12), exp_pm(m_t, hour_12));
            end
        end
        wr_bus.load = 1'b0; alarm_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rollover();
        test_12h();
        test_load_err();
        test_coincident();
`ifdef CLK_ALARM_EN
        test_alarm();
`endif
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
